// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory burst initiator
package mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  localparam logic MEM_WR = 1'b1;
  localparam logic MEM_RD = 1'b0;

  // Galois feedback taps for the 8-bit fill pattern generator
  localparam logic [7:0] LFSR_TAP = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_init_lfsr.sv
// rtl/mem_init_lfsr.sv - Galois LFSR fill-pattern source, seed 1, advances on enable
// Instantiated only when MEM_INIT_LFSR_EN is defined.
module mem_init_lfsr
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] TAP = WIDTH'(LFSR_TAP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_o <= WIDTH'(1);
    end else if (en_i) begin
      state_o <= (state_o >> 1) ^ (state_o[0] ? TAP : '0);
    end
  end

endmodule

// File: rtl/mem_burst_initiator.sv
// rtl/mem_burst_initiator.sv - turns one burst command into per-beat memory valid/ready requests
// Define MEM_INIT_LFSR_EN to source write data from mem_init_lfsr instead of the write stream.
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_rd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_count_i,
  input  logic                  wr_data_valid_i,
  output logic                  wr_data_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_data_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  rd_wr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i
);

  localparam int CW = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic                  cmd_ready_q;
  logic                  rd_wr_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         beat_q;
  logic                  rd_pend_q;

  logic                  accept;
  logic                  hs;
  logic                  beats_left;
  logic                  last_beat;
  logic                  wr_avail;
  logic [WIDTH-1:0]      wr_src;

  assign accept     = cmd_valid_i & cmd_ready_q;
  assign hs         = valid_o & ready_i;
  assign beats_left = (beat_q != count_q);
  assign last_beat  = ((beat_q + CW'(1)) == count_q);

`ifdef MEM_INIT_LFSR_EN
  logic unused_stream;

  assign unused_stream   = ^{wr_data_i, wr_data_valid_i};
  assign wr_data_ready_o = 1'b0;
  assign wr_avail        = 1'b1;

  mem_init_lfsr #(
    .WIDTH(WIDTH)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (hs & (rd_wr_q == MEM_WR)),
    .state_o(wr_src)
  );
`else
  logic             full_q;
  logic [WIDTH-1:0] data_q;
  logic             load;

  // Refill in the same cycle the held word leaves so writes sustain one beat per cycle.
  assign wr_data_ready_o = (state_q == ISSUE) && (rd_wr_q == MEM_WR) &&
                           (!full_q || (hs && !last_beat));
  assign load            = wr_data_ready_o & wr_data_valid_i;
  assign wr_avail        = full_q;
  assign wr_src          = data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= wr_data_i;
    end else if (hs) begin
      full_q <= 1'b0;
    end
  end
`endif

  assign valid_o = (state_q == ISSUE) && ((rd_wr_q == MEM_WR) ? wr_avail : beats_left);
  assign rd_wr_o = rd_wr_q;
  assign addr_o  = start_q + beat_q[ADDR_WIDTH-1:0];
  assign wdata_o = (valid_o && (rd_wr_q == MEM_WR)) ? wr_src : '0;

  assign cmd_ready_o     = cmd_ready_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign rd_data_valid_o = rd_pend_q;
  assign rd_data_o       = rd_pend_q ? rdata_i : '0;

  // Reads stay in ISSUE one cycle past the last handshake while its word is returned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (cmd_count_i == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (rd_wr_q == MEM_WR) begin
          if (hs && last_beat) state_d = DONE;
        end else if (!beats_left) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rd_wr_q     <= MEM_RD;
      start_q     <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      rd_pend_q   <= hs && (rd_wr_q == MEM_RD);
      if (accept) begin
        rd_wr_q <= cmd_rd_wr_i;
        start_q <= cmd_addr_i;
        count_q <= cmd_count_i;
        beat_q  <= '0;
      end else if (hs) begin
        beat_q  <= beat_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// tb/tb_mem_burst_initiator.sv - directed self-checking bench for mem_burst_initiator
// Define MEM_INIT_LFSR_EN to exercise the LFSR fill build instead of the stream write cases.
module tb_mem_burst_initiator;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i, cmd_ready_o, cmd_rd_wr_i;
  logic [AW-1:0] cmd_addr_i;
  logic [AW:0]   cmd_count_i;
  logic          wr_data_valid_i, wr_data_ready_o;
  logic [7:0]    wr_data_i;
  logic          rd_data_valid_o;
  logic [7:0]    rd_data_o;
  logic          busy_o, done_o, valid_o, ready_i, rd_wr_o;
  logic [AW-1:0] addr_o;
  logic [7:0]    wdata_o, rdata_i;

  always #5 clk = ~clk;

  mem_burst_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rd_wr_i(cmd_rd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_count_i(cmd_count_i),
    .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o), .wr_data_i(wr_data_i),
    .rd_data_valid_o(rd_data_valid_o), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .ready_i(ready_i),
    .rd_wr_o(rd_wr_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  // Memory responder: write on handshake, read data returned the following cycle.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (valid_o && ready_i) begin
      if (rd_wr_o) mem[addr_o] <= wdata_o;
      else         rdata_i     <= mem[addr_o];
    end
  end

  int         checks = 0;
  int         fails  = 0;
  int         cyc, done_n, done_cyc, last_pulse_cyc, sidx;
  bit         wrdy_seen;
  logic [3:0] hs_addr [$];
  logic [7:0] hs_data [$];
  logic [7:0] rd_q    [$];
  logic [7:0] stream  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {valid_o, busy_o, done_o, cmd_ready_o, rd_data_valid_o, wr_data_ready_o,
                rd_wr_o, addr_o, wdata_o, rd_data_o}, 32'h0);
  endtask

  task automatic step(input logic rdy, input logic dv, input logic cv);
    @(negedge clk);
    ready_i         = rdy;
    wr_data_valid_i = dv;
    cmd_valid_i     = cv;
    wr_data_i       = (sidx < stream.size()) ? stream[sidx] : 8'h00;
    #1;
    cyc++;
    if (wr_data_ready_o) wrdy_seen = 1'b1;
    if (wr_data_ready_o && dv) sidx++;
    if (valid_o && ready_i) begin
      hs_addr.push_back(addr_o);
      hs_data.push_back(wdata_o);
    end
    if (rd_data_valid_o) begin
      rd_q.push_back(rd_data_o);
      last_pulse_cyc = cyc;
    end
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [AW-1:0] addr, input logic [AW:0] count);
    @(negedge clk);
    cmd_valid_i     = 1'b1;
    cmd_rd_wr_i     = rw;
    cmd_addr_i      = addr;
    cmd_count_i     = count;
    ready_i         = 1'b0;
    wr_data_valid_i = 1'b0;
    #1;
    check("cmd_ready_idle", cmd_ready_o, 1);
    hs_addr.delete(); hs_data.delete(); rd_q.delete();
    cyc = 0; done_n = 0; done_cyc = -1; last_pulse_cyc = -1; sidx = 0; wrdy_seen = 1'b0;
  endtask

  task automatic run(input logic rdy, input logic dv, input logic cv, input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      step(rdy, dv, cv);
      n++;
    end
    check("burst_done", done_n, 1);
  endtask

  task automatic set_stream(input logic [7:0] base, input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(base + 8'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_rd_wr_i = 1'b0; cmd_addr_i = '0; cmd_count_i = '0;
    wr_data_valid_i = 1'b0; wr_data_i = '0; ready_i = 1'b0;
    cyc = 0; done_n = 0; done_cyc = -1; last_pulse_cyc = -1; sidx = 0; wrdy_seen = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_outs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_at_release", cmd_ready_o, 0);
    @(negedge clk);
    #1 check("cmd_ready_after_clock", cmd_ready_o, 1);

`ifdef MEM_INIT_LFSR_EN
    send_cmd(1'b1, 4'd0, 5'd3);
    run(1'b1, 1'b1, 1'b0, 20);
    check("lfsr_latency", done_cyc, 4);
    check("lfsr_mem0", mem[0], 8'h01);
    check("lfsr_mem1", mem[1], 8'hB8);
    check("lfsr_mem2", mem[2], 8'h5C);
    check("lfsr_wr_ready_never", wrdy_seen, 0);
`else
    // Full 16-word write from address 0.
    set_stream(8'h10, 16);
    send_cmd(1'b1, 4'd0, 5'd16);
    run(1'b1, 1'b1, 1'b0, 40);
    check("wr16_latency", done_cyc, 18);
    check("wr16_beats", hs_addr.size(), 16);
    for (int i = 0; i < 16 && i < hs_addr.size(); i++) begin
      check("wr16_addr", hs_addr[i], 32'(i));
      check("wr16_data", hs_data[i], 32'(8'h10 + 8'(i)));
    end
    for (int i = 0; i < 16; i++) check("wr16_mem", mem[i], 32'(8'h10 + 8'(i)));

    // Read back four words from address 4.
    send_cmd(1'b0, 4'd4, 5'd4);
    step(1'b1, 1'b0, 1'b0);
    check("rd4_busy", busy_o, 1);
    check("rd4_cmd_ready_busy", cmd_ready_o, 0);
    run(1'b1, 1'b0, 1'b0, 20);
    check("rd4_latency", done_cyc, 7);
    check("rd4_pulses", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) check("rd4_data", rd_q[i], 32'(8'h14 + 8'(i)));
    check("rd4_done_gap", done_cyc - last_pulse_cyc, 2);

    // Address wrap, with a competing command held valid throughout the burst.
    set_stream(8'h20, 4);
    send_cmd(1'b1, 4'd14, 5'd4);
    step(1'b1, 1'b1, 1'b1);
    cmd_rd_wr_i = 1'b0; cmd_addr_i = 4'd0; cmd_count_i = 5'd5;
    run(1'b1, 1'b1, 1'b1, 20);
    check("wrap_latency", done_cyc, 6);
    check("wrap_beats", hs_addr.size(), 4);
    check("wrap_addrs", {hs_addr[0], hs_addr[1], hs_addr[2], hs_addr[3]}, 32'hEF01);
    check("wrap_mem", {mem[14], mem[15], mem[0], mem[1]}, 32'h20212223);

    // Memory backpressure 1,0,0,1 then a three-cycle write-stream gap.
    set_stream(8'h30, 4);
    send_cmd(1'b1, 4'd8, 5'd4);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("bp_stall1", {valid_o, addr_o, wdata_o}, {1'b1, 4'd8, 8'h30});
    step(1'b0, 1'b1, 1'b0);
    check("bp_stall2", {valid_o, addr_o, wdata_o}, {1'b1, 4'd8, 8'h30});
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("bp_gap1_valid", valid_o, 0);
    step(1'b1, 1'b0, 1'b0);
    check("bp_gap2_valid", valid_o, 0);
    step(1'b1, 1'b1, 1'b0);
    check("bp_gap3_valid", valid_o, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("bp_stall3", {valid_o, addr_o, wdata_o}, {1'b1, 4'd11, 8'h33});
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("bp_done_cycle", done_cyc, 12);
    check("bp_beats", hs_addr.size(), 4);
    check("bp_addrs", {hs_addr[0], hs_addr[1], hs_addr[2], hs_addr[3]}, 32'h89AB);
    check("bp_data", {hs_data[0], hs_data[1], hs_data[2], hs_data[3]}, 32'h30313233);
    check("bp_consumed", sidx, 4);
`endif

    // Zero-length burst completes without touching memory.
    send_cmd(1'b1, 4'd3, 5'd0);
    step(1'b1, 1'b1, 1'b0);
    check("zero_done", done_o, 1);
    check("zero_no_valid", valid_o, 0);
    check("zero_no_beats", hs_addr.size(), 0);

    // Reset in the middle of a 16-beat read while a read pulse is pending.
    send_cmd(1'b0, 4'd0, 5'd16);
    for (int n = 0; n < 20 && hs_addr.size() < 5; n++) step(1'b1, 1'b0, 1'b0);
    check("mid_beats_before_reset", hs_addr.size(), 5);
    @(negedge clk);
    #1 check("mid_pulse_pending", rd_data_valid_o, 1);
    rst_n = 1'b0;
    #1 check_outs_zero("mid_reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_cmd_ready_at_release", cmd_ready_o, 0);
    @(negedge clk);
    #1 check("mid_cmd_ready_after", {cmd_ready_o, busy_o, done_o, valid_o}, 4'b1000);
    @(negedge clk);
    #1 check("mid_no_done", {busy_o, done_o}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
- Hardware initiator for the memory valid/ready/rd_wr access protocol; it drives the request side that the memory block responds to.
- Accepts one burst command (read or write, start address, count) and issues one memory transaction per beat.
- Write beats take data from an upstream stream; read beats return data on a downstream stream.
- Sits between a control/DMA client and memory1; replaces bench-driven front-door access in system-level designs.

Parameters:
- WIDTH, 8, data width; must match the memory.
- DEPTH, 16, memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH), address width.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  asynchronous, active-low reset.
- cmd_valid_i  input  1  burst command valid.
- cmd_ready_o  output  1  high only in IDLE; the command is accepted when cmd_valid_i and cmd_ready_o are both high at a posedge.
- cmd_rd_wr_i  input  1  1 = write burst, 0 = read burst.
- cmd_addr_i  input  ADDR_WIDTH  start address.
- cmd_count_i  input  ADDR_WIDTH+1  beats, 0..DEPTH.
- wr_data_valid_i  input  1  write-data stream valid.
- wr_data_ready_o  output  1  write word consumed this cycle.
- wr_data_i  input  WIDTH  write data.
- rd_data_valid_o  output  1  one-cycle pulse per read word.
- rd_data_o  output  WIDTH  read data.
- busy_o  output  1  high outside IDLE.
- done_o  output  1  one-cycle pulse when the burst completes.
- valid_o  output  1  memory request valid.
- ready_i  input  1  memory ready.
- rd_wr_o  output  1  memory direction.
- addr_o  output  ADDR_WIDTH  memory address.
- wdata_o  output  WIDTH  memory write data.
- rdata_i  input  WIDTH  memory read data.

Behaviour:
- Reset values: all outputs 0, including cmd_ready_o. cmd_ready_o goes to 1 on the first clock after reset release. FSM = IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On command accept, latch rd_wr, addr and count; beat counter = 0.
  - If count == 0, go to DONE; otherwise go to ISSUE.
- ISSUE, memory side:
  - Drive valid_o, rd_wr_o and addr_o (= start + beat, modulo DEPTH, i.e. natural ADDR_WIDTH wrap).
  - A beat completes on a posedge with valid_o & ready_i.
  - valid_o, addr_o, rd_wr_o and wdata_o stay stable until the beat completes.
  - valid_o never drops without a completion, except on reset.
- ISSUE, write beats:
  - valid_o is asserted only once a word is held in the internal data register.
  - Register load: wr_data_ready_o = 1 when the register is empty and the FSM is in ISSUE; the word loads when wr_data_valid_i is also high.
  - The register empties on beat completion.
  - An empty stream stalls the burst with valid_o = 0; this is not an error.
- ISSUE, read beats:
  - rdata_i is valid on the cycle after the handshake.
  - rd_data_valid_o pulses with rd_data_o = rdata_i on that following cycle.
  - Back-to-back read handshakes are allowed, giving one word per cycle.
- Burst end:
  - After the last write beat completes, go to DONE.
  - After the last read beat completes, go to DRAIN for one cycle, capture the final read data, then go to DONE.
- DONE: done_o = 1 for one cycle, then return to IDLE. busy_o = 1 in ISSUE, DRAIN and DONE.
- Boundary conditions:
  - count == DEPTH starting at addr A touches every word once, ending at A-1 mod DEPTH.
  - Commands arriving while busy are not accepted (cmd_ready_o = 0).
  - ready_i is ignored while valid_o = 0.
  - Reset mid-burst: immediately return to IDLE with outputs at reset values. The partial burst is abandoned, no done_o is issued, and any pending read pulse is suppressed.
- Throughput: first request is issued the cycle after accept. Minimum burst latency is count + 2 cycles for writes (register prefill) and count + 3 cycles for reads, from accept to done_o.

Optional Feature:
- Macro: MEM_INIT_LFSR_EN.
- When defined:
  - Write data comes from an internal WIDTH-bit Galois LFSR with seed 1 after reset.
  - The LFSR advances once per completed write beat.
  - wr_data_ready_o is tied 0 and wr_data_i/wr_data_valid_i are ignored.
  - Write beats never stall.
  - Used for memory fill/self-test.
- When undefined: no LFSR is present and the stream interface is used as above.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - the rd_wr encoding constants (MEM_WR = 1, MEM_RD = 0);
  - the LFSR tap constant (8'hB8 for WIDTH = 8);
  - the default WIDTH/DEPTH.
- One sub-module, mem_init_lfsr (enable, state out), instantiated only under MEM_INIT_LFSR_EN.

Test Plan:
- Write burst: addr 0, count 16, stream 8'h10..8'h1F, memory ready_i = 1 → 16 handshakes at addr 0..15; backdoor dump of memory shows 10..1F; one done_o.
- Read burst: after the above, addr 4, count 4 → rd_data_valid_o pulses 4 times with 14,15,16,17; done_o follows the last pulse by 2 cycles.
- Wrap: write addr 14, count 4 → addr_o sequence 14,15,0,1.
- Backpressure: ready_i toggling 1,0,0,1 and a write-stream gap of 3 cycles → addr_o/wdata_o stable while stalled, valid_o low during the gap, no lost or duplicated beat.
- Zero and reset: count 0 → done_o on the cycle after accept, no valid_o. A separate case asserts rst_i low at beat 5 of 16 → all outputs 0 at once, cmd_ready_o = 1 after release.
- With MEM_INIT_LFSR_EN: write count 3 at addr 0 → memory holds 01, B8, 5C; wr_data_ready_o never high.
